// File: rtl/line_segment_scheduler.sv
// Per-scanline scheduler: during horizontal blanking, scans a double-buffered segment table and
// assigns the segments that cover the next line to a fixed pool of evaluator slots.
module line_segment_scheduler #(
    parameter int unsigned NUM_SEG   = 8,
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned H_TOTAL   = 1344,
    parameter int unsigned V_ACTIVE  = 768,
    parameter int unsigned V_TOTAL   = 806,
    localparam int unsigned AW       = $clog2(NUM_SEG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [10:0]             hcount,
    input  logic [9:0]              vcount,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic                    wr_valid,
    input  logic [10:0]             wr_start_x,
    input  logic [10:0]             wr_end_x,
    input  logic [9:0]              wr_start_y,
    input  logic [9:0]              wr_end_y,
    input  logic                    commit,
    output logic                    commit_pending,
    output logic [NUM_SLOTS-1:0]    slot_valid,
    output logic [11*NUM_SLOTS-1:0] slot_start_x,
    output logic [11*NUM_SLOTS-1:0] slot_end_x,
    output logic [10*NUM_SLOTS-1:0] slot_start_y,
    output logic [10*NUM_SLOTS-1:0] slot_end_y,
    output logic                    line_overflow,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(NUM_SLOTS + 1);

    typedef struct packed {
        logic        v;
        logic [10:0] sx;
        logic [10:0] ex;
        logic [9:0]  sy;
        logic [9:0]  ey;
    } seg_t;

    typedef enum logic [1:0] {StIdle, StScan, StWait} state_e;

    state_e        state_q, state_d;
    seg_t          shadow_q [NUM_SEG];
    seg_t          active_q [NUM_SEG];
    seg_t          stg_q    [NUM_SLOTS];
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic [AW-1:0] idx_q;
    logic [9:0]    ty_q;
    logic          pending_q;

    logic [9:0] ty;
    logic       trigger, swap, publish, last, hit;
    seg_t       cur;
    logic [9:0] lo, hi;

    assign ty      = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    assign trigger = (state_q == StIdle) && (hcount == 11'(H_ACTIVE));
    assign swap    = trigger && (ty == 10'd0) && pending_q;
    assign publish = (state_q == StWait) && (hcount == 11'(H_TOTAL - 1));
    assign last    = (idx_q == AW'(NUM_SEG - 1));

    assign cur = active_q[idx_q];
    assign lo  = (cur.sy < cur.ey) ? cur.sy : cur.ey;
    assign hi  = (cur.sy < cur.ey) ? cur.ey : cur.sy;
    // Lines in vertical blanking never schedule anything.
    assign hit = (state_q == StScan) && cur.v && (lo <= ty_q) && (ty_q <= hi)
                 && (ty_q < 10'(V_ACTIVE));

    assign busy           = (state_q == StScan);
    assign commit_pending = pending_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trigger) state_d = StScan;
            StScan:  if (last) state_d = StWait;
            StWait:  if (publish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SEG; i++) shadow_q[i] <= '0;
        end else if (wr_en) begin
            shadow_q[wr_addr] <= '{v: wr_valid, sx: wr_start_x, ex: wr_end_x,
                                   sy: wr_start_y, ey: wr_end_y};
        end
    end

    // The swap copies the pre-edge shadow, so a write on the same edge waits for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SEG; i++) active_q[i] <= '0;
            pending_q <= 1'b0;
        end else if (swap) begin
            for (int i = 0; i < NUM_SEG; i++) active_q[i] <= shadow_q[i];
            pending_q <= commit;
        end else if (commit) begin
            pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) stg_q[k] <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            idx_q <= '0;
            ty_q  <= '0;
        end else if (trigger) begin
            for (int k = 0; k < NUM_SLOTS; k++) stg_q[k] <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            idx_q <= '0;
            ty_q  <= ty;
        end else if (state_q == StScan) begin
            idx_q <= idx_q + AW'(1);
            if (hit) begin
                if (cnt_q == CW'(NUM_SLOTS)) begin
                    ovf_q <= 1'b1;
                end else begin
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        if (cnt_q == CW'(k)) stg_q[k] <= cur;
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid    <= '0;
            slot_start_x  <= '0;
            slot_end_x    <= '0;
            slot_start_y  <= '0;
            slot_end_y    <= '0;
            line_overflow <= 1'b0;
        end else if (publish) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_valid[k]            <= stg_q[k].v;
                slot_start_x[11*k +: 11] <= stg_q[k].sx;
                slot_end_x[11*k +: 11]   <= stg_q[k].ex;
                slot_start_y[10*k +: 10] <= stg_q[k].sy;
                slot_end_y[10*k +: 10]   <= stg_q[k].ey;
            end
            line_overflow <= ovf_q;
        end
    end

endmodule

// File: tb/tb_line_segment_scheduler.sv
// Scoreboard bench for line_segment_scheduler: line tasks queue the expected published slots,
// a monitor pops them at each line start and re-checks them at the end of the line.
module tb_line_segment_scheduler;

    localparam int NSEG = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic        wr_valid = 1'b0;
    logic [10:0] wr_start_x = '0, wr_end_x = '0;
    logic [9:0]  wr_start_y = '0, wr_end_y = '0;
    logic        commit = 1'b0;
    logic        commit_pending, line_overflow, busy;
    logic [1:0]  slot_valid;
    logic [21:0] slot_start_x, slot_end_x;
    logic [19:0] slot_start_y, slot_end_y;

    line_segment_scheduler dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_valid(wr_valid),
        .wr_start_x(wr_start_x), .wr_end_x(wr_end_x),
        .wr_start_y(wr_start_y), .wr_end_y(wr_end_y),
        .commit(commit), .commit_pending(commit_pending),
        .slot_valid(slot_valid), .slot_start_x(slot_start_x), .slot_end_x(slot_end_x),
        .slot_start_y(slot_start_y), .slot_end_y(slot_end_y),
        .line_overflow(line_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  v;
        logic [21:0] sx;
        logic [21:0] ex;
        logic [19:0] sy;
        logic [19:0] ey;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    exp_t e0;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [1:0] v, input int sx0, input int sy0,
                                input int ex0, input int ey0, input int sx1, input int sy1,
                                input int ex1, input int ey1, input logic ovf);
        exp_t e;
        e.v   = v;
        e.sx  = {11'(sx1), 11'(sx0)};
        e.ex  = {11'(ex1), 11'(ex0)};
        e.sy  = {10'(sy1), 10'(sy0)};
        e.ey  = {10'(ey1), 10'(ey0)};
        e.ovf = ovf;
        return e;
    endfunction

    function automatic exp_t mk1(input int sx, input int sy, input int ex, input int ey);
        return mk(2'b01, sx, sy, ex, ey, 0, 0, 0, 0, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int h);
        hcount = 11'(h);
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int a, input int sx, input int sy, input int ex, input int ey,
                          input logic v);
        wr_addr    = 3'(a);
        wr_valid   = v;
        wr_start_x = 11'(sx);
        wr_start_y = 10'(sy);
        wr_end_x   = 11'(ex);
        wr_end_y   = 10'(ey);
    endtask

    task automatic wr(input int a, input int sx, input int sy, input int ex, input int ey);
        set_wr(a, sx, sy, ex, ey, 1'b1);
        wr_en = 1'b1;
        cyc(0);
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cyc(0);
        commit = 1'b0;
    endtask

    // One compressed line: trigger, scan, publish; inj asserts write+commit on the trigger edge.
    task automatic do_line(input int v, input exp_t e, input bit inj);
        vcount = 10'(v);
        cyc(0);
        for (int h = 1024; h <= 1024 + NSEG + 2; h++) begin
            if (inj && h == 1024) begin
                wr_en  = 1'b1;
                commit = 1'b1;
            end
            cyc(h);
            wr_en  = 1'b0;
            commit = 1'b0;
            if (h == 1024) chk("busy_scan", 128'(busy), 128'(1));
            if (h == 1024 + NSEG) chk("busy_done", 128'(busy), 128'(0));
        end
        q.push_back(e);
        cyc(1343);
        cyc(0);
    endtask

    // Monitor: pop at the first cycle of each line, re-check the same values at hcount 1343.
    int   prev_h = 0;
    bit   have_cur = 0;
    bit   rst_seen = 0;
    always @(negedge clk) begin
        exp_t a;
        a.v = slot_valid;  a.sx = slot_start_x; a.ex = slot_end_x;
        a.sy = slot_start_y; a.ey = slot_end_y; a.ovf = line_overflow;
        if (reset) rst_seen = 1;
        if (hcount == 11'd0 && prev_h == 1343) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got output with no expectation");
            end else begin
                cur_exp = q.pop_front();
                chk("line_slots", 128'(a), 128'(cur_exp));
                have_cur = 1;
                rst_seen = 0;
            end
        end else if (hcount == 11'd1343 && have_cur && !rst_seen) begin
            chk("line_stable", 128'(a), 128'(cur_exp));
        end
        prev_h = int'(hcount);
    end

    initial begin
        e0 = '0;
        repeat (3) cyc(0);
        reset = 1'b0;
        cyc(0);
        chk("rst_pending", 128'(commit_pending), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_slots", 128'({slot_valid, slot_start_x, slot_end_y, line_overflow}), 128'(0));

        // Single segment, committed mid-frame, visible from line 50 of the next frame.
        vcount = 10'd10;
        wr(0, 100, 200, 300, 50);
        do_commit();
        chk("pending_set", 128'(commit_pending), 128'(1));
        do_line(10, e0, 0);
        chk("pending_hold", 128'(commit_pending), 128'(1));
        do_line(805, e0, 0);
        chk("pending_clr", 128'(commit_pending), 128'(0));
        do_line(48, e0, 0);
        do_line(49, mk1(100, 200, 300, 50), 0);

        // Three segments on line 400: two scheduled in index order, overflow flagged.
        wr(0, 10, 390, 20, 400);
        wr(3, 30, 400, 40, 400);
        wr(5, 50, 380, 60, 420);
        do_commit();
        do_line(805, e0, 0);
        do_line(399, mk(2'b11, 10, 390, 20, 400, 30, 400, 40, 400, 1'b1), 0);
        do_line(400, mk1(50, 380, 60, 420), 0);

        // Uncommitted write stays invisible across frames.
        wr(2, 1, 401, 2, 401);
        for (int f = 0; f < 3; f++) begin
            do_line(805, e0, 0);
            do_line(400, mk1(50, 380, 60, 420), 0);
        end
        do_commit();
        do_line(400, mk1(50, 380, 60, 420), 0);
        do_line(805, e0, 0);
        do_line(400, mk(2'b11, 1, 401, 2, 401, 50, 380, 60, 420, 1'b0), 0);

        // Write and commit on the swap edge.
        wr(1, 7, 600, 8, 600);
        do_commit();
        set_wr(7, 5, 600, 6, 600, 1'b1);
        do_line(805, e0, 1);
        chk("pending_reset_on_swap", 128'(commit_pending), 128'(1));
        do_line(599, mk1(7, 600, 8, 600), 0);
        do_line(805, e0, 0);
        chk("pending_clr2", 128'(commit_pending), 128'(0));
        do_line(599, mk(2'b11, 7, 600, 8, 600, 5, 600, 6, 600, 1'b0), 0);

        // Horizontal segment on the last visible line, and one entirely in blanking.
        wr(4, 11, 767, 12, 767);
        wr(6, 13, 800, 14, 805);
        do_commit();
        do_line(805, e0, 0);
        do_line(765, e0, 0);
        do_line(767, e0, 0);
        do_line(801, e0, 0);
        do_line(766, mk1(11, 767, 12, 767), 0);

        // Reset in the middle of a scan.
        do_commit();
        chk("pending_pre_rst", 128'(commit_pending), 128'(1));
        vcount = 10'd399;
        cyc(0);
        for (int h = 1024; h <= 1027; h++) cyc(h);
        reset  = 1'b1;
        hcount = 11'd1028;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_valid", 128'(slot_valid), 128'(0));
        chk("midrst_pending", 128'(commit_pending), 128'(0));
        cyc(1028);
        cyc(1029);
        reset = 1'b0;
        for (int h = 1030; h <= 1040; h++) cyc(h);
        q.push_back(e0);
        cyc(1343);
        cyc(0);
        do_line(399, e0, 0);

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_segment_scheduler.md
Name: line_segment_scheduler

Overview:
- Per-scanline scheduler that shares a small, fixed pool of line-evaluator slots (get_shape instances) among a larger table of line segments.
- During horizontal blanking it scans a double-buffered segment table and picks the segments whose y-span covers the next scanline. It then presents their endpoints on NUM_SLOTS slot buses for the whole of that line.
- The host writes the shadow table and commits it. The commit takes effect at the next frame boundary, so no tearing occurs.

Parameters:
- NUM_SEG, 8, segment table entries (power of 2; index width log2(NUM_SEG)=AW).
- NUM_SLOTS, 2, evaluator slots driven per scanline.
- H_ACTIVE, 1024, first hcount of horizontal blanking.
- H_TOTAL, 1344, hcount period.
- V_ACTIVE, 768, visible lines.
- V_TOTAL, 806, vcount period.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- hcount  in  11  current pixel column.
- vcount  in  10  current line.
- wr_en  in  1  write shadow entry this cycle.
- wr_addr  in  AW  shadow entry index.
- wr_valid  in  1  entry enable bit written with the entry.
- wr_start_x, wr_end_x  in  11 each  endpoint x.
- wr_start_y, wr_end_y  in  10 each  endpoint y.
- commit  in  1  one-cycle request to publish the shadow table.
- commit_pending  out  1  commit accepted, swap not yet done.
- slot_valid  out  NUM_SLOTS  slot k drives a segment this line.
- slot_start_x, slot_end_x  out  11*NUM_SLOTS  slot k at bits [11k+10:11k].
- slot_start_y, slot_end_y  out  10*NUM_SLOTS  slot k at bits [10k+9:10k].
- line_overflow  out  1  more than NUM_SLOTS segments hit the current line.
- busy  out  1  scan in progress.

Behaviour:
- Reset (async): all shadow and active valid bits 0; coordinates 0; slot_* 0; line_overflow 0; commit_pending 0; busy 0; FSM IDLE.
- Shadow write: on wr_en, shadow[wr_addr] takes all five fields on the rising edge. Writes never touch the active table.
- Commit: commit sets commit_pending on the next edge. A repeated commit while pending has no further effect.
- Target line: ty = 0 if vcount == V_TOTAL-1, else vcount+1.
- Scan trigger: on the cycle hcount == H_ACTIVE, the FSM goes IDLE -> SCAN, idx = 0, staging cleared, busy = 1.
- Swap: if ty == 0 and commit_pending is set at the trigger cycle, the full shadow table is copied to active on that edge and commit_pending clears.
  - The scan then reads the new active contents.
  - A wr_en on the swap edge is not copied; it stays in shadow only.
  - A commit on the swap edge re-sets commit_pending.
  - Shadow keeps its contents after the swap, so host edits are incremental.
- SCAN: one entry per cycle, idx 0..NUM_SEG-1.
  - Hit = valid && min(sy,ey) <= ty <= max(sy,ey), unsigned 10-bit compares.
  - A horizontal segment (sy == ey == ty) is a hit.
  - Hits fill staging slots in ascending idx order.
  - A hit with all slots already full sets staging overflow; that segment is dropped.
  - If ty >= V_ACTIVE, no hits are recorded.
- After idx = NUM_SEG-1: SCAN -> WAIT, busy = 0. Scan time is NUM_SEG cycles. Constraint: NUM_SEG <= H_TOTAL-H_ACTIVE-2.
- Publish: on the edge where hcount == H_TOTAL-1, the FSM goes WAIT -> IDLE. Staging copies to slot_* and line_overflow.
  - Outputs change only at this edge, so they are stable from hcount 0 through the whole line.
  - Unused slots have slot_valid 0 and coordinates 0.
- Reset mid-scan: outputs and state go to reset values immediately. The next trigger starts a clean scan with an empty active table.
- hcount/vcount jumps: a trigger during SCAN or WAIT is ignored. The next trigger after IDLE proceeds normally.

Test Plan:
- Entry 0 = (100,200)-(300,50), valid; commit during line 10 of frame N -> commit_pending = 1 until the swap cycle (vcount = 805, hcount = 1024). At vcount = 49 hcount = 0 of frame N+1: slot_valid = 0. At vcount = 50: slot_valid = 01, slot0 = (100,200,300,50).
- Entries 0, 3, 5 all spanning y = 400, NUM_SLOTS = 2 -> on line 400: slots hold entries 0 and 3 in order, line_overflow = 1. Line 401 with only entry 5 covering it -> slot0 = entry 5, line_overflow = 0.
- Write entry 2 without commit -> active table unchanged across 3 frames. Commit -> change visible only from line 0 of the following frame.
- Commit and wr_en asserted on the swap edge -> active gets the pre-write shadow, commit_pending = 1 afterwards, and the write appears after the next frame swap.
- Assert reset at hcount = 1028 (mid-scan) for 2 cycles -> busy = 0, slot_valid = 0, commit_pending = 0 immediately. The following line's scan yields no hits.
- Horizontal segment sy = ey = 767 -> appears on line 767 only. Segment with sy = 800 -> never scheduled. Slot outputs are unchanged for hcount 0..1343 of every line.
